// File: rtl/multi_buffer_controller.sv
// Triple+/N-buffer frame controller: writer/reader id grants 1 cycle after request, valid held until request drops.
// No stall path (free buffer always exists). Optional counters under `MULTI_BUFFER_STATS_EN`.
module multi_buffer_controller #(
    parameter int NUM_BUFFERS = 3,
    parameter int ID_WIDTH    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                write_rq_rdy,
    input  logic                finalize_wr,
    input  logic                read_rq_rdy,
    input  logic                finalize_rd,
    output logic                wr_id_valid,
    output logic [ID_WIDTH-1:0] wr_id,
    output logic                rd_id_valid,
    output logic [ID_WIDTH-1:0] rd_id,
    output logic                frame_drop,
    output logic                rd_repeat
`ifdef MULTI_BUFFER_STATS_EN
    ,
    output logic [15:0]         drop_count,
    output logic [15:0]         repeat_count
`endif
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} chan_state_t;

    chan_state_t         wr_state, wr_state_nxt, rd_state, rd_state_nxt;
    logic [ID_WIDTH-1:0] wr_idx, rd_idx, latest_idx, latest_eff, alloc_idx;
    logic                wr_active, rd_active, fresh;
    logic                wr_take, rd_take, wr_fin, rd_fin, wr_reuse, rd_reuse;

    always_comb begin
        wr_take    = (wr_state == IDLE) && write_rq_rdy;
        rd_take    = (rd_state == IDLE) && read_rq_rdy;
        wr_fin     = finalize_wr && wr_active;
        rd_fin     = finalize_rd && rd_active;
        // A finalize in the same cycle as a request ends the old buffer, so the request allocates anew.
        wr_reuse   = wr_active && !finalize_wr;
        rd_reuse   = rd_active && !finalize_rd;
        latest_eff = wr_fin ? wr_idx : latest_idx;
    end

    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
            if ((ID_WIDTH'(i) != latest_eff) && !(rd_active && (ID_WIDTH'(i) == rd_idx)))
                alloc_idx = ID_WIDTH'(i);
        end
    end

    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            IDLE:    if (write_rq_rdy) wr_state_nxt = GRANT;
            GRANT:   if (!write_rq_rdy) wr_state_nxt = RELEASE;
            RELEASE: wr_state_nxt = IDLE;
            default: wr_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            IDLE:    if (read_rq_rdy) rd_state_nxt = GRANT;
            GRANT:   if (!read_rq_rdy) rd_state_nxt = RELEASE;
            RELEASE: rd_state_nxt = IDLE;
            default: rd_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state   <= IDLE;
            rd_state   <= IDLE;
            wr_idx     <= '0;
            rd_idx     <= '0;
            latest_idx <= '0;
            wr_active  <= 1'b0;
            rd_active  <= 1'b0;
            fresh      <= 1'b1;
            frame_drop <= 1'b0;
            rd_repeat  <= 1'b0;
        end else begin
            wr_state   <= wr_state_nxt;
            rd_state   <= rd_state_nxt;
            frame_drop <= wr_fin && fresh;
            rd_repeat  <= rd_take && !rd_reuse && !fresh;
            if (wr_fin) begin
                latest_idx <= wr_idx;
                wr_active  <= 1'b0;
            end
            if (wr_take && !wr_reuse) begin
                wr_idx    <= alloc_idx;
                wr_active <= 1'b1;
            end
            if (rd_fin)
                rd_active <= 1'b0;
            if (rd_take && !rd_reuse) begin
                rd_idx    <= latest_idx;
                rd_active <= 1'b1;
            end
            // A frame finalized while the reader grabs the old latest stays fresh.
            if (wr_fin)
                fresh <= 1'b1;
            else if (rd_take && !rd_reuse)
                fresh <= 1'b0;
        end
    end

    assign wr_id_valid = (wr_state == GRANT);
    assign rd_id_valid = (rd_state == GRANT);
    assign wr_id       = wr_idx;
    assign rd_id       = rd_idx;

`ifdef MULTI_BUFFER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count   <= '0;
            repeat_count <= '0;
        end else begin
            if (frame_drop && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
            if (rd_repeat && (repeat_count != 16'hFFFF))
                repeat_count <= repeat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multi_buffer_controller.sv
// Directed bench: default 3-buffer instance plus a 5-buffer/3-bit instance driven with identical stimulus.
module tb_multi_buffer_controller;

    logic       clk = 1'b0;
    logic       reset, write_rq_rdy, finalize_wr, read_rq_rdy, finalize_rd;
    logic       wr_id_valid, rd_id_valid, frame_drop, rd_repeat;
    logic [1:0] wr_id, rd_id;
    logic       wr_id_valid5, rd_id_valid5, frame_drop5, rd_repeat5;
    logic [2:0] wr_id5, rd_id5;
`ifdef MULTI_BUFFER_STATS_EN
    logic [15:0] drop_count, repeat_count, drop_count5, repeat_count5;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    multi_buffer_controller dut (
        .clk(clk), .reset(reset),
        .write_rq_rdy(write_rq_rdy), .finalize_wr(finalize_wr),
        .read_rq_rdy(read_rq_rdy), .finalize_rd(finalize_rd),
        .wr_id_valid(wr_id_valid), .wr_id(wr_id),
        .rd_id_valid(rd_id_valid), .rd_id(rd_id),
        .frame_drop(frame_drop), .rd_repeat(rd_repeat)
`ifdef MULTI_BUFFER_STATS_EN
        , .drop_count(drop_count), .repeat_count(repeat_count)
`endif
    );

    multi_buffer_controller #(.NUM_BUFFERS(5), .ID_WIDTH(3)) dut5 (
        .clk(clk), .reset(reset),
        .write_rq_rdy(write_rq_rdy), .finalize_wr(finalize_wr),
        .read_rq_rdy(read_rq_rdy), .finalize_rd(finalize_rd),
        .wr_id_valid(wr_id_valid5), .wr_id(wr_id5),
        .rd_id_valid(rd_id_valid5), .rd_id(rd_id5),
        .frame_drop(frame_drop5), .rd_repeat(rd_repeat5)
`ifdef MULTI_BUFFER_STATS_EN
        , .drop_count(drop_count5), .repeat_count(repeat_count5)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        write_rq_rdy = 1'b0; read_rq_rdy = 1'b0;
        finalize_wr = 1'b0; finalize_rd = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic wr_grant(input logic [2:0] exp);
        write_rq_rdy = 1'b1;
        tick();
        chk("wr_vld", wr_id_valid, 1);
        chk("wr_vld5", wr_id_valid5, 1);
        chk("wr_id", wr_id, exp);
        chk("wr_id5", wr_id5, exp);
        write_rq_rdy = 1'b0;
        tick();
        chk("wr_rel", wr_id_valid, 0);
        tick();
    endtask

    task automatic rd_grant(input logic [2:0] exp, input logic exp_rep);
        read_rq_rdy = 1'b1;
        tick();
        chk("rd_vld", rd_id_valid, 1);
        chk("rd_id", rd_id, exp);
        chk("rd_id5", rd_id5, exp);
        chk("rd_rep", rd_repeat, exp_rep);
        chk("rd_rep5", rd_repeat5, exp_rep);
        read_rq_rdy = 1'b0;
        tick();
        chk("rd_rel", rd_id_valid, 0);
        chk("rd_rep_end", rd_repeat, 0);
        tick();
    endtask

    task automatic fin_wr(input logic exp_drop);
        finalize_wr = 1'b1;
        tick();
        finalize_wr = 1'b0;
        chk("drop", frame_drop, exp_drop);
        chk("drop5", frame_drop5, exp_drop);
        tick();
        chk("drop_end", frame_drop, 0);
    endtask

    task automatic fin_rd();
        finalize_rd = 1'b1;
        tick();
        finalize_rd = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_wr_vld", wr_id_valid, 0);
        chk("rst_rd_vld", rd_id_valid, 0);
        chk("rst_wr_id", wr_id, 0);
        chk("rst_rd_id", rd_id, 0);
        chk("rst_drop", frame_drop, 0);
        chk("rst_rep", rd_repeat, 0);

        // First grants after reset, then one frame read repeatedly.
        wr_grant(3'd1);
        rd_grant(3'd0, 1'b0);
        fin_rd();
        fin_wr(1'b0);
        for (int i = 0; i < 10; i++) begin
            rd_grant(3'd1, (i != 0));
            fin_rd();
        end

        // Reader holds 0, writer cycles through 1 then 2; second finalize drops an unread frame.
        do_reset();
        rd_grant(3'd0, 1'b0);
        wr_grant(3'd1);
        fin_wr(1'b0);
        wr_grant(3'd2);
        fin_wr(1'b1);

        // Both channels granted together, then reset aborts them mid-grant.
        write_rq_rdy = 1'b1; read_rq_rdy = 1'b1;
        tick();
        chk("both_wr_vld", wr_id_valid, 1);
        chk("both_rd_vld", rd_id_valid, 1);
        chk("both_wr_id", wr_id, 1);
        chk("both_wr_id5", wr_id5, 1);
        chk("both_rd_id", rd_id, 0);
        chk("regrant_rep", rd_repeat, 0);
        reset = 1'b1; write_rq_rdy = 1'b0; read_rq_rdy = 1'b0;
        tick();
        chk("abort_wr", wr_id_valid, 0);
        chk("abort_rd", rd_id_valid, 0);
        chk("abort_wr5", wr_id_valid5, 0);
        chk("abort_rd5", rd_id_valid5, 0);
        reset = 1'b0;
        tick();

        // Finalize of buffer 1 coincides with a read request: reader gets the old latest.
        do_reset();
        wr_grant(3'd1);
        finalize_wr = 1'b1; read_rq_rdy = 1'b1;
        tick();
        finalize_wr = 1'b0;
        chk("race_rd_vld", rd_id_valid, 1);
        chk("race_rd_id", rd_id, 0);
        chk("race_rep", rd_repeat, 0);
        read_rq_rdy = 1'b0;
        tick(); tick();
        fin_rd();
        rd_grant(3'd1, 1'b0);
        fin_rd();
        fin_wr(1'b0);
        rd_grant(3'd1, 1'b1);
        fin_rd();

        // Three drops and four repeats from a clean reset.
        do_reset();
        wr_grant(3'd1);
        fin_wr(1'b1);
        wr_grant(3'd0);
        fin_wr(1'b1);
        wr_grant(3'd1);
        fin_wr(1'b1);
        rd_grant(3'd1, 1'b0);
        fin_rd();
        for (int i = 0; i < 4; i++) begin
            rd_grant(3'd1, 1'b1);
            fin_rd();
        end
`ifdef MULTI_BUFFER_STATS_EN
        chk("drop_count", drop_count, 3);
        chk("repeat_count", repeat_count, 4);
        chk("drop_count5", drop_count5, 3);
        chk("repeat_count5", repeat_count5, 4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multi_buffer_controller.md
MULTI_BUFFER_CONTROLLER -- requirements
Module: multi_buffer_controller

Interface
REQ-001 Parameter NUM_BUFFERS, default 3, number of frame buffers; legal range 3..8.
REQ-002 Parameter ID_WIDTH, default 2, buffer index width; SHALL be >= clog2(NUM_BUFFERS).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 write_rq_rdy  input  1  writer requests a buffer (level, held until wr_id_valid seen).
REQ-006 finalize_wr  input  1  one-cycle pulse: writer finished current buffer.
REQ-007 read_rq_rdy  input  1  reader requests a buffer (level, held until rd_id_valid seen).
REQ-008 finalize_rd  input  1  one-cycle pulse: reader finished current buffer.
REQ-009 wr_id_valid  output  1  wr_id is valid.
REQ-010 wr_id  output  ID_WIDTH  buffer granted to writer.
REQ-011 rd_id_valid  output  1  rd_id is valid.
REQ-012 rd_id  output  ID_WIDTH  buffer granted to reader.
REQ-013 frame_drop  output  1  one-cycle pulse: a completed frame was overwritten as latest before being read.
REQ-014 rd_repeat  output  1  one-cycle pulse: reader granted a frame it has already read.

Function
REQ-015 Internal state SHALL be: wr_idx, wr_active, rd_idx, rd_active, latest_idx, fresh (latest not yet read).
REQ-016 Write and read channels SHALL be independent; both may be granted in the same cycle.
REQ-017 Channel handshake per channel: states IDLE -> GRANT -> RELEASE -> IDLE.
REQ-018 IDLE: request high -> grant computed and registered; valid rises the next cycle (latency 1); go to GRANT.
REQ-019 GRANT: valid and id held stable while request high; request low -> valid falls the next cycle; go to RELEASE.
REQ-020 RELEASE: one cycle with valid low; return to IDLE; a request held high in RELEASE is served from IDLE.
REQ-021 Write grant: lowest index != latest_idx and != rd_idx when rd_active; sets wr_idx, wr_active=1.
REQ-022 Write request while wr_active=1: re-grant current wr_idx, no new allocation.
REQ-023 Read grant: rd_idx = latest_idx, rd_active=1, fresh=0; rd_repeat pulses the same cycle valid rises if fresh was 0.
REQ-024 Read request while rd_active=1: re-grant current rd_idx, fresh unchanged, no rd_repeat.
REQ-025 finalize_wr with wr_active=1: latest_idx=wr_idx, fresh=1, wr_active=0; frame_drop pulses next cycle if fresh was 1.
REQ-026 finalize_wr with wr_active=0, or finalize_rd with rd_active=0: ignored, no state change.
REQ-027 finalize_rd with rd_active=1: rd_active=0; rd_idx retained but excluded from no allocation.
REQ-028 Same cycle finalize_wr and read grant: reader receives the pre-update latest_idx; the new frame remains fresh.
REQ-029 Same cycle finalize_rd and write grant: allocation uses pre-update rd_active.
REQ-030 With NUM_BUFFERS >= 3 a write grant SHALL always find a free buffer; no stall path exists.

Reset
REQ-031 On reset: wr_id_valid=0, rd_id_valid=0, wr_id=0, rd_id=0, frame_drop=0, rd_repeat=0.
REQ-032 On reset: latest_idx=0, fresh=1, wr_active=0, rd_active=0, both channels IDLE.
REQ-033 Reset mid-handshake SHALL abort both channels; valids low the cycle after reset is sampled.

Configuration
REQ-034 Macro MULTI_BUFFER_STATS_EN defined: add outputs drop_count[15:0], repeat_count[15:0].
REQ-035 The counters increment on frame_drop and rd_repeat, saturate at 16'hFFFF, and clear on reset.
REQ-036 Macro undefined: the count ports and counters are absent; all other behaviour is identical.

Verification
REQ-037 After reset, write request -> wr_id=1; read request -> rd_id=0, no rd_repeat.
REQ-038 Write 1, finalize_wr, then 10 read/finalize_rd cycles -> rd_id=1 every time; rd_repeat pulses on reads 2..10.
REQ-039 NUM_BUFFERS=3, reader holds 0, writer finalizes 1 then requests -> wr_id=2; finalize_wr without a read -> frame_drop pulse.
REQ-040 Simultaneous finalize_wr of buffer 1 and read request -> rd_id=0; the next read after finalize_rd -> rd_id=1.
REQ-041 NUM_BUFFERS=5, ID_WIDTH=3, with rd_active on 0 and latest=1, writer requests -> wr_id=2; reset asserted during GRANT -> valids low next cycle.
REQ-042 With MULTI_BUFFER_STATS_EN defined, 3 drops and 4 repeats -> drop_count=3, repeat_count=4.
